// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// Module  : branch_resolve_ctrl
// Purpose : RV32I conditional-branch resolver with fetch-redirect handshake.
//           Optional statistics counters: define BRANCH_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_ctrl #(
  parameter int REDIR_TIMEOUT = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             resolve_done,
  output logic             resolve_taken,
  output logic             illegal_err,
  output logic             misalign_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_EVAL  = 2'd1;
  localparam logic [1:0] c_REDIR = 2'd2;
  localparam int         c_TW    = (REDIR_TIMEOUT > 0) ? $clog2(REDIR_TIMEOUT + 1) : 1;
  localparam logic [c_TW-1:0] c_TMO = c_TW'(REDIR_TIMEOUT);

  logic [1:0]      r_state;
  logic [31:0]     r_instr;
  logic [31:0]     r_pc;
  logic [31:0]     r_rs1;
  logic [31:0]     r_rs2;
  logic [31:0]     r_redirect_pc;
  logic [c_TW-1:0] r_tcnt;

  logic [2:0]  w_funct3;
  logic [31:0] w_imm;
  logic [31:0] w_target;
  logic        w_illegal;
  logic        w_eq;
  logic        w_lt;
  logic        w_ltu;
  logic        w_cond;
  logic        w_taken;
  logic        w_in_eval;
  logic        w_in_redir;
  logic        w_tmo_hit;
  logic        w_handshake;
  logic        w_tmo;
  logic        w_unused_rs_fields;

  // Register-index fields are irrelevant here; operands arrive pre-read.
  assign w_unused_rs_fields = ^r_instr[24:15];

  assign w_funct3  = r_instr[14:12];
  assign w_imm     = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
  assign w_target  = r_pc + w_imm;
  assign w_illegal = (r_instr[6:0] != 7'b1100011) || (w_funct3[2:1] == 2'b01);
  assign w_eq      = (r_rs1 == r_rs2);
  assign w_lt      = ($signed(r_rs1) < $signed(r_rs2));
  assign w_ltu     = (r_rs1 < r_rs2);

  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken     = ~w_illegal & w_cond;
  // Outputs are gated by reset so every output reads 0 while reset is held.
  assign w_in_eval   = (r_state == c_EVAL)  & ~reset;
  assign w_in_redir  = (r_state == c_REDIR) & ~reset;
  assign w_tmo_hit   = (REDIR_TIMEOUT != 0) && (r_tcnt == c_TMO);
  assign w_handshake = w_in_redir & redirect_ready;
  assign w_tmo       = w_in_redir & ~redirect_ready & w_tmo_hit;

  assign req_ready      = (r_state == c_IDLE) & ~reset;
  assign redirect_valid = w_in_redir;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = w_handshake;
  assign resolve_done   = (w_in_eval & ~(w_taken & ~w_target[1])) | w_handshake | w_tmo;
  assign resolve_taken  = (w_in_eval & w_taken & w_target[1]) | w_handshake;
  assign illegal_err    = w_in_eval & w_illegal;
  assign misalign_err   = w_in_eval & w_taken & w_target[1];
  assign timeout_err    = w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_instr       <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_redirect_pc <= '0;
      r_tcnt        <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_tcnt <= '0;
          if (req_valid) begin
            r_instr <= instr;
            r_pc    <= pc;
            r_rs1   <= rs1_data;
            r_rs2   <= rs2_data;
            r_state <= c_EVAL;
          end
        end
        c_EVAL: begin
          r_tcnt <= '0;
          if (w_taken && !w_target[1]) begin
            r_redirect_pc <= w_target;
            r_state       <= c_REDIR;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_REDIR: begin
          if (redirect_ready || w_tmo_hit) begin
            r_state <= c_IDLE;
          end else if (REDIR_TIMEOUT != 0) begin
            r_tcnt <= r_tcnt + c_TW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_ntaken_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_cnt  <= '0;
      r_ntaken_cnt <= '0;
    end else begin
      if (resolve_done && resolve_taken && !(&r_taken_cnt))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      // Timeouts are excluded: that branch was taken but never redirected.
      if (w_in_eval && !w_illegal && !w_taken && !(&r_ntaken_cnt))
        r_ntaken_cnt <= r_ntaken_cnt + CNT_W'(1);
    end
  end

  assign taken_cnt  = r_taken_cnt;
  assign ntaken_cnt = r_ntaken_cnt;
`else
  assign taken_cnt  = '0;
  assign ntaken_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// ============================================================================
// Module  : tb_branch_resolve_ctrl
// Purpose : Scoreboard bench for branch_resolve_ctrl (timeout 0 and 4 builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;

  logic req_valid = 1'b0, redirect_ready = 1'b1;
  logic req_ready, redirect_valid, flush, resolve_done, resolve_taken;
  logic illegal_err, misalign_err, timeout_err;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

  logic t_req_valid = 1'b0, t_redirect_ready = 1'b0;
  logic t_req_ready, t_redirect_valid, t_flush, t_resolve_done, t_resolve_taken;
  logic t_illegal_err, t_misalign_err, t_timeout_err;
  logic [31:0] t_redirect_pc;
  logic [CNT_W-1:0] t_taken_cnt, t_ntaken_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.REDIR_TIMEOUT(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .resolve_done(resolve_done),
    .resolve_taken(resolve_taken), .illegal_err(illegal_err),
    .misalign_err(misalign_err), .timeout_err(timeout_err),
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  branch_resolve_ctrl #(.REDIR_TIMEOUT(4), .CNT_W(CNT_W)) dut_to (
    .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .redirect_valid(t_redirect_valid), .redirect_ready(t_redirect_ready),
    .redirect_pc(t_redirect_pc), .flush(t_flush), .resolve_done(t_resolve_done),
    .resolve_taken(t_resolve_taken), .illegal_err(t_illegal_err),
    .misalign_err(t_misalign_err), .timeout_err(t_timeout_err),
    .taken_cnt(t_taken_cnt), .ntaken_cnt(t_ntaken_cnt)
  );

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic        misalign;
    logic        flush;
    logic [31:0] target;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_flush_seen = 0;
  int n_flush_exp  = 0;
  int n_tk_exp     = 0;
  int n_ntk_exp    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour of one request, written from the ISA definition.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] imm;
    logic        c;
    e   = '0;
    imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    e.target = p + imm;
    c = 1'b0;
    if (ins[6:0] != 7'h63 || ins[14:12] == 3'd2 || ins[14:12] == 3'd3) begin
      e.illegal = 1'b1;
    end else begin
      case (ins[14:12])
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = ($signed(a) <  $signed(b));
        3'd5: c = ($signed(a) >= $signed(b));
        3'd6: c = (a <  b);
        default: c = (a >= b);
      endcase
    end
    if (c) begin
      e.taken = 1'b1;
      if (e.target[1]) e.misalign = 1'b1;
      else             e.flush    = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) n_flush_seen++;
      if (resolve_done) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("sb_taken",    {31'd0, resolve_taken}, {31'd0, e.taken});
          check_eq("sb_illegal",  {31'd0, illegal_err},   {31'd0, e.illegal});
          check_eq("sb_misalign", {31'd0, misalign_err},  {31'd0, e.misalign});
          check_eq("sb_flush",    {31'd0, flush},         {31'd0, e.flush});
          check_eq("sb_timeout",  {31'd0, timeout_err},   32'd0);
          if (e.flush) begin
            check_eq("sb_redir_pc", redirect_pc, e.target);
            n_flush_exp++;
          end
          if (e.taken) n_tk_exp++;
          else if (!e.illegal) n_ntk_exp++;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("issue_ready_wait", 32'd0, 32'd1);
    instr = ins; pc = p; rs1_data = a; rs2_data = b; req_valid = 1'b1;
    sb_q.push_back(model(ins, p, a, b));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue_to(input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    check_eq("to_req_ready", {31'd0, t_req_ready}, 32'd1);
    instr = ins; pc = p; rs1_data = 32'd5; rs2_data = 32'd5; t_req_valid = 1'b1;
    @(posedge clk);
    #1 t_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, a, b, ins;
    logic [12:0] im;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [6];
    legal_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_outputs", {26'd0, redirect_valid, flush, resolve_done, illegal_err,
                             misalign_err, timeout_err}, 32'd0);
    check_eq("rst_counters", {taken_cnt, ntaken_cnt}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Taken BEQ, immediate handshake
    redirect_ready = 1'b1;
    issue(32'h0020_8463, 32'h100, 32'd5, 32'd5);
    @(negedge clk);
    check_eq("beq_eval_no_redir", {30'd0, redirect_valid, resolve_done}, 32'd0);
    @(negedge clk);
    check_eq("beq_redir", {29'd0, redirect_valid, flush, resolve_done}, 32'd7);
    check_eq("beq_pc", redirect_pc, 32'h108);

    // Not-taken BNE
    issue(32'h0020_9463, 32'h100, 32'd5, 32'd5);
    @(negedge clk);
    check_eq("bne_eval", {28'd0, resolve_done, resolve_taken, redirect_valid, flush}, 32'h8);
    check_eq("bne_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_eq("bne_idle", {30'd0, req_ready, redirect_valid}, 32'd2);

    // Signed vs unsigned compare
    issue(32'hFE20_CEE3, 32'h200, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("blt_pc", redirect_pc, 32'h1FC);
    issue(32'hFE20_EEE3, 32'h200, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    check_eq("bltu_not_taken", {30'd0, resolve_done, resolve_taken}, 32'd2);

    // Backpressure: ready low for 3 REDIR cycles
    redirect_ready = 1'b0;
    issue(32'h0020_8463, 32'h300, 32'd7, 32'd7);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_hold", {redirect_valid, req_ready, flush, resolve_done, 28'd0},
               {4'b1000, 28'd0});
      check_eq("bp_pc", redirect_pc, 32'h308);
    end
    @(posedge clk);
    #1 redirect_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", {29'd0, redirect_valid, flush, resolve_done}, 32'd7);
    check_eq("bp_pc_final", redirect_pc, 32'h308);
    @(negedge clk);
    check_eq("bp_next_ready", {30'd0, req_ready, flush}, 32'd2);

    // Misaligned taken target
    issue(32'h0020_8363, 32'h100, 32'd1, 32'd1);
    @(negedge clk);
    check_eq("mis_eval", {28'd0, misalign_err, resolve_done, resolve_taken, flush}, 32'hE);
    @(negedge clk);
    check_eq("mis_no_redir", {31'd0, redirect_valid}, 32'd0);

    // Illegal funct3 and illegal opcode
    issue(32'h0020_A463, 32'h100, 32'd1, 32'd1);
    @(negedge clk);
    check_eq("ill_f3", {29'd0, illegal_err, resolve_done, resolve_taken}, 32'd6);
    issue(32'h0020_8413, 32'h100, 32'd1, 32'd1);
    @(negedge clk);
    check_eq("ill_opcode", {30'd0, illegal_err, resolve_done}, 32'd3);

    // Random legal branches through the scoreboard
    for (int n = 0; n < 24; n++) begin
      r  = $urandom;
      im = r[12:0];
      im[0] = 1'b0;
      f3 = legal_f3[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      ins = {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
      r  = $urandom;
      issue(ins, {r[31:2], 2'b00}, a, b);
    end

    // Timeout instance: ready never arrives
    t_redirect_ready = 1'b0;
    issue_to(32'h0020_8463, 32'h100);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("to_wait", {30'd0, t_redirect_valid, t_timeout_err}, 32'd2);
    end
    @(negedge clk);
    check_eq("to_fire", {27'd0, t_timeout_err, t_resolve_done, t_flush, t_resolve_taken,
                         t_illegal_err | t_misalign_err}, 32'h18);
    check_eq("to_pc", t_redirect_pc, 32'h108);
    @(negedge clk);
    check_eq("to_after", {30'd0, t_redirect_valid, t_req_ready}, 32'd1);

    // Handshake wins in the cycle the count reaches the limit
    issue_to(32'h0020_8463, 32'h100);
    @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 t_redirect_ready = 1'b1;
    @(negedge clk);
    check_eq("to_hs_wins", {29'd0, t_flush, t_resolve_done, t_timeout_err}, 32'd6);
    t_redirect_ready = 1'b0;

    // Async reset in the middle of REDIR
    redirect_ready = 1'b0;
    issue(32'h0020_8463, 32'h400, 32'd3, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check_eq("ar_in_redir", {31'd0, redirect_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_outputs", {28'd0, redirect_valid, flush, req_ready, resolve_done}, 32'd0);
    sb_q.delete();
    n_tk_exp = 0;
    n_ntk_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    check_eq("ar_idle", {30'd0, req_ready, redirect_valid}, 32'd2);
    check_eq("ar_counters", {taken_cnt, ntaken_cnt}, 32'd0);
    issue(32'h0020_9463, 32'h500, 32'd9, 32'd9);
    repeat (3) @(negedge clk);

    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("flush_count", n_flush_seen, n_flush_exp);
`ifdef BRANCH_STATS_EN
    check_eq("stat_taken",  {16'd0, taken_cnt},  n_tk_exp);
    check_eq("stat_ntaken", {16'd0, ntaken_cnt}, n_ntk_exp);
`else
    check_eq("stat_taken",  {16'd0, taken_cnt},  32'd0);
    check_eq("stat_ntaken", {16'd0, ntaken_cnt}, 32'd0);
`endif
    check_eq("to_stat_tied", {t_taken_cnt, t_ntaken_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Multi-cycle branch resolution controller for the RV32I core.
- Accepts one conditional-branch instruction at a time with its PC and operands, and decodes the B-type immediate internally.
- Evaluates the branch condition and computes the target.
- Sequences the fetch redirect over a valid/ready handshake, raising a one-cycle pipeline flush when the redirect is accepted.

Parameters:
- REDIR_TIMEOUT, 0, cycles to wait in REDIR for redirect_ready before abandoning; 0 = wait forever.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  branch request present.
- req_ready  out  1  controller can accept a request.
- instr  in  32  instruction word.
- pc  in  32  PC of the instruction.
- rs1_data  in  32  rs1 operand.
- rs2_data  in  32  rs2 operand.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  32  branch target.
- flush  out  1  one-cycle flush of younger instructions.
- resolve_done  out  1  one-cycle pulse: current request retired.
- resolve_taken  out  1  valid with resolve_done: branch taken.
- illegal_err  out  1  pulse with resolve_done: funct3 010/011 or opcode not 1100011.
- misalign_err  out  1  pulse with resolve_done: taken target has bit 1 set.
- timeout_err  out  1  pulse: REDIR abandoned.
- taken_cnt  out  CNT_W  taken branches (optional feature).
- ntaken_cnt  out  CNT_W  not-taken branches (optional feature).

Behaviour:
- Reset: one clock, asynchronous active-high reset named clk/reset. While reset is high, the state is IDLE and every output is 0, including req_ready and the counters. Reset asserted mid-operation aborts immediately; there is no flush and no done.
- Immediate: imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}. Target = pc + imm, modulo 2^32 (wraps silently).
- FSM states: IDLE, EVAL, REDIR.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch instr, pc, rs1_data and rs2_data, then go to EVAL.
  - Inputs are ignored outside this handshake.
- EVAL (exactly one cycle, req_ready = 0):
  - Conditions from latched data: funct3 000 BEQ (equal), 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - Illegal funct3 or opcode: resolve_done=1, resolve_taken=0, illegal_err=1, go to IDLE.
  - Not taken: resolve_done=1, resolve_taken=0, go to IDLE.
  - Taken with target[1]=1: resolve_done=1, resolve_taken=1, misalign_err=1, no redirect, no flush, go to IDLE.
  - Taken and aligned: go to REDIR. redirect_pc is registered and holds the target from here on.
- REDIR:
  - redirect_valid = 1; redirect_pc is held stable until the handshake.
  - On redirect_ready=1 in a REDIR cycle: flush=1, resolve_done=1, resolve_taken=1 in that same cycle; next state IDLE.
  - redirect_valid must not drop without a handshake, except on timeout or reset.
- Timeout (REDIR_TIMEOUT>0):
  - The counter clears on REDIR entry and increments each cycle without ready.
  - When it reaches REDIR_TIMEOUT: timeout_err=1 and resolve_done=1 for one cycle, no flush, go to IDLE.
  - If ready arrives in the same cycle the count reaches REDIR_TIMEOUT, the handshake wins.
- Latency:
  - Request accepted at edge N; EVAL occupies cycle N+1.
  - Not-taken done in cycle N+1.
  - Taken redirect_valid from cycle N+2.
  - Minimum back-to-back issue interval: 2 cycles not-taken, 3 cycles taken.
- Pulses: done, flush and the error flags are high for exactly one cycle per request. Two error flags never assert together.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - taken_cnt increments on each taken resolve_done, including misaligned taken branches.
  - ntaken_cnt increments on each not-taken, non-illegal resolve_done.
  - Both saturate at all-ones and clear only on reset.
- Undefined: both ports are present and tied to 0; no counter flops are generated.

Test Plan:
- Taken redirect: instr=0x00208463 (beq x1,x2,+8), pc=0x100, rs1=rs2=5, redirect_ready=1 → redirect_valid in cycle N+2, redirect_pc=0x108, flush+resolve_done+resolve_taken same cycle.
- Not taken: instr=0x00209463 (bne +8), rs1=rs2=5 → resolve_done in N+1, resolve_taken=0, no redirect_valid, no flush.
- Signed vs unsigned: instr=0xFE20CEE3 (blt x1,x2,-4), pc=0x200, rs1=0xFFFFFFFF, rs2=0 → taken, redirect_pc=0x1FC. Same operands with funct3=110 (BLTU) → not taken.
- Backpressure: taken branch with redirect_ready=0 for 3 cycles then 1 (REDIR_TIMEOUT=0) → redirect_valid/redirect_pc stable for 4 cycles, req_ready=0 throughout, single flush pulse, new req accepted next cycle.
- Errors: instr=0x00208363 (beq +6) taken → misalign_err+resolve_done, no flush. funct3=010 → illegal_err. REDIR_TIMEOUT=4 with ready held 0 → timeout_err after 4 REDIR cycles.
- Async reset asserted mid-cycle in REDIR → redirect_valid, flush and req_ready go 0 immediately. After release: IDLE, req_ready=1, counters 0.
